mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter in front of a single shared memory port.
// Each requester has one pending slot; one memory transaction is in flight
// at a time, and a transaction with no mem_ack is aborted after
// TIMEOUT_CYCLES cycles in WAIT.
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   cN_addr, cN_wr_data    requester N address / write data (N = 0, 1)
//   cN_rd_req, cN_wr_req   requester N one-cycle request pulses
//   cN_rd_data             read data returned with cN_ack (0 for writes/aborts)
//   cN_ack                 one-cycle completion pulse to requester N
//   cN_busy                requester N has a pending or in-flight transaction
//   mem_addr, mem_wr_data  address / write data to the memory
//   mem_rd_req, mem_wr_req one-cycle memory request pulses
//   mem_rd_data, mem_ack   memory read data and completion pulse
//   mem_busy               memory cannot accept a request this cycle
//   err                    one-cycle pulse on a timeout abort
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transaction in flight; grant a valid slot when !mem_busy
// S_WAIT  | request issued, waiting for mem_ack or the timeout
// S_ABORT | one cycle after a timeout; err/cN_ack are visible here
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wr_data,
  input  logic        c0_rd_req,
  input  logic        c0_wr_req,
  output logic [31:0] c0_rd_data,
  output logic        c0_ack,
  output logic        c0_busy,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wr_data,
  input  logic        c1_rd_req,
  input  logic        c1_wr_req,
  output logic [31:0] c1_rd_data,
  output logic        c1_ack,
  output logic        c1_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack,
  input  logic        mem_busy,
  output logic        err
);

  // The counter only has to reach TIMEOUT_CYCLES-1: the abort decision is
  // taken at the edge that would complete the last allowed WAIT cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             s0_valid;
  logic             s0_we;
  logic [31:0]      s0_addr;
  logic [31:0]      s0_wdata;
  logic             s1_valid;
  logic             s1_we;
  logic [31:0]      s1_addr;
  logic [31:0]      s1_wdata;

  logic             cur_port;
  logic             cur_we;
  logic             last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic             grant_en;
  logic             grant_port;
  logic             done_ok;
  logic             done_abort;
  logic             done;
  logic             fin0;
  logic             fin1;
  logic             c0_cap;
  logic             c1_cap;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [31:0]      rd_ret;

  // A slot that is valid (pending or in flight) drops further pulses.
  assign c0_cap = (c0_rd_req | c0_wr_req) & ~s0_valid;
  assign c1_cap = (c1_rd_req | c1_wr_req) & ~s1_valid;

  assign done = done_ok | done_abort;
  assign fin0 = done & ~cur_port;
  assign fin1 = done & cur_port;

  assign rd_ret = (done_ok & ~cur_we) ? mem_rd_data : 32'd0;

  assign c0_busy = s0_valid;
  assign c1_busy = s1_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    grant_port = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mem_busy && (s0_valid || s1_valid)) begin
          grant_en = 1'b1;
          if (s0_valid && s1_valid) begin
            grant_port = ~last_grant;
          end else begin
            grant_port = s1_valid;
          end
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real ack on the final cycle still wins over the timeout.
        if (mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          done_abort = 1'b1;
          state_nxt  = S_ABORT;
        end
      end
      S_ABORT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_we    = s0_we;
    sel_addr  = s0_addr;
    sel_wdata = s0_wdata;
    if (grant_port) begin
      sel_we    = s1_we;
      sel_addr  = s1_addr;
      sel_wdata = s1_wdata;
    end
  end

  // A completing slot is never capturing at the same edge (it is valid), so
  // the clear and the load are exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid <= 1'b0;
      s0_we    <= 1'b0;
      s0_addr  <= 32'd0;
      s0_wdata <= 32'd0;
    end else if (fin0) begin
      s0_valid <= 1'b0;
    end else if (c0_cap) begin
      s0_valid <= 1'b1;
      s0_we    <= c0_wr_req;
      s0_addr  <= c0_addr;
      s0_wdata <= c0_wr_req ? c0_wr_data : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_addr  <= 32'd0;
      s1_wdata <= 32'd0;
    end else if (fin1) begin
      s1_valid <= 1'b0;
    end else if (c1_cap) begin
      s1_valid <= 1'b1;
      s1_we    <= c1_wr_req;
      s1_addr  <= c1_addr;
      s1_wdata <= c1_wr_req ? c1_wr_data : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      if (grant_en) begin
        cur_port <= grant_port;
        cur_we   <= sel_we;
        wait_cnt <= '0;
      end else if (done) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (done) begin
        last_grant <= cur_port;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wr_data <= 32'd0;
    end else begin
      mem_rd_req <= grant_en & ~sel_we;
      mem_wr_req <= grant_en & sel_we;
      if (grant_en) begin
        mem_addr    <= sel_addr;
        mem_wr_data <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_ack     <= 1'b0;
      c1_ack     <= 1'b0;
      c0_rd_data <= 32'd0;
      c1_rd_data <= 32'd0;
      err        <= 1'b0;
    end else begin
      c0_ack <= fin0;
      c1_ack <= fin1;
      err    <= done_abort;
      if (fin0) begin
        c0_rd_data <= rd_ret;
      end
      if (fin1) begin
        c1_rd_data <= rd_ret;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] c0_addr = 32'd0;
  logic [31:0] c0_wr_data = 32'd0;
  logic        c0_rd_req = 1'b0;
  logic        c0_wr_req = 1'b0;
  logic [31:0] c0_rd_data;
  logic        c0_ack;
  logic        c0_busy;
  logic [31:0] c1_addr = 32'd0;
  logic [31:0] c1_wr_data = 32'd0;
  logic        c1_rd_req = 1'b0;
  logic        c1_wr_req = 1'b0;
  logic [31:0] c1_rd_data;
  logic        c1_ack;
  logic        c1_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_rd_data = 32'd0;
  logic        mem_ack;
  logic        mem_busy = 1'b0;
  logic        err;

  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;
  assign mem_ack = resp_ack | late_ack;

  int          n_checks = 0;
  int          n_err = 0;
  int          ack_delay = 2;
  logic        mem_mute = 1'b0;
  int          cd = 0;
  logic [31:0] lat_addr = 32'd0;

  mem_arbiter #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst),
    .c0_addr(c0_addr), .c0_wr_data(c0_wr_data), .c0_rd_req(c0_rd_req),
    .c0_wr_req(c0_wr_req), .c0_rd_data(c0_rd_data), .c0_ack(c0_ack), .c0_busy(c0_busy),
    .c1_addr(c1_addr), .c1_wr_data(c1_wr_data), .c1_rd_req(c1_rd_req),
    .c1_wr_req(c1_wr_req), .c1_rd_data(c1_rd_data), .c1_ack(c1_ack), .c1_busy(c1_busy),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'd7);
  endfunction

  // Memory responder: acks ack_delay cycles after seeing a request.
  initial begin
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (mem_mute) begin
        cd = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        lat_addr = mem_addr;
        cd = ack_delay;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          resp_ack = 1'b1;
          mem_rd_data = mem_fn(lat_addr);
        end
      end
    end
  end

  // Transaction-level reference: per-port pending requests, one transaction
  // in flight with its age, and a dead cycle after a timeout.
  logic        p_v[2];
  logic        p_w[2];
  logic [31:0] p_a[2];
  logic [31:0] p_d[2];
  logic        fly;
  int          fport;
  int          fage;
  logic        hold;
  int          last;
  logic        e_ack[2];
  logic [31:0] e_rdd[2];
  logic        e_mrd;
  logic        e_mwr;
  logic        e_err;
  logic [31:0] e_maddr;
  logic [31:0] e_mwd;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_w[i] = 1'b0; p_a[i] = 32'd0; p_d[i] = 32'd0;
      e_ack[i] = 1'b0; e_rdd[i] = 32'd0;
    end
    fly = 1'b0; fport = 0; fage = 0; hold = 1'b0; last = 1;
    e_mrd = 1'b0; e_mwr = 1'b0; e_err = 1'b0; e_maddr = 32'd0; e_mwd = 32'd0;
  endtask

  task automatic m_step();
    logic cap0;
    logic cap1;
    int   pick;
    cap0 = (c0_rd_req || c0_wr_req) && !p_v[0];
    cap1 = (c1_rd_req || c1_wr_req) && !p_v[1];
    e_ack[0] = 1'b0; e_ack[1] = 1'b0;
    e_mrd = 1'b0; e_mwr = 1'b0; e_err = 1'b0;
    if (fly) begin
      if (mem_ack || (fage + 1 == TOUT)) begin
        e_ack[fport] = 1'b1;
        e_rdd[fport] = (mem_ack && !p_w[fport]) ? mem_rd_data : 32'd0;
        e_err = !mem_ack;
        hold = !mem_ack;
        p_v[fport] = 1'b0;
        last = fport;
        fly = 1'b0;
      end else begin
        fage++;
      end
    end else if (hold) begin
      hold = 1'b0;
    end else if ((p_v[0] || p_v[1]) && !mem_busy) begin
      if (p_v[0] && p_v[1]) pick = 1 - last;
      else pick = p_v[0] ? 0 : 1;
      e_mrd = !p_w[pick];
      e_mwr = p_w[pick];
      e_maddr = p_a[pick];
      e_mwd = p_d[pick];
      fly = 1'b1; fport = pick; fage = 0;
    end
    if (cap0) begin
      p_v[0] = 1'b1; p_a[0] = c0_addr; p_w[0] = c0_wr_req;
      p_d[0] = c0_wr_req ? c0_wr_data : 32'd0;
    end
    if (cap1) begin
      p_v[1] = 1'b1; p_a[1] = c1_addr; p_w[1] = c1_wr_req;
      p_d[1] = c1_wr_req ? c1_wr_data : 32'd0;
    end
  endtask

  task automatic compare();
    chk1("m_c0_ack", c0_ack, e_ack[0]);
    chk1("m_c1_ack", c1_ack, e_ack[1]);
    chk32("m_c0_rd_data", c0_rd_data, e_rdd[0]);
    chk32("m_c1_rd_data", c1_rd_data, e_rdd[1]);
    chk1("m_c0_busy", c0_busy, p_v[0]);
    chk1("m_c1_busy", c1_busy, p_v[1]);
    chk1("m_mem_rd_req", mem_rd_req, e_mrd);
    chk1("m_mem_wr_req", mem_wr_req, e_mwr);
    chk32("m_mem_addr", mem_addr, e_maddr);
    chk1("m_err", err, e_err);
    if (e_mwr) chk32("m_mem_wr_data", mem_wr_data, e_mwd);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
      #1;
      compare();
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    int glog[$];
    int n0;
    int n1;

    // reset state
    cyc();
    cyc();
    chk1("rst_c0_ack", c0_ack, 1'b0);
    chk1("rst_c0_busy", c0_busy, 1'b0);
    chk1("rst_mem_rd_req", mem_rd_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_c1_rd_data", c1_rd_data, 32'd0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b1;

    // single read, ack 2 cycles after request
    cyc();
    c0_rd_req = 1'b1; c0_addr = 32'h40;
    cyc();
    c0_rd_req = 1'b0;
    chk1("t1_busy_set", c0_busy, 1'b1);
    cyc();
    chk1("t1_mem_rd_req", mem_rd_req, 1'b1);
    chk32("t1_mem_addr", mem_addr, 32'h40);
    cyc();
    chk1("t1_req_pulse_end", mem_rd_req, 1'b0);
    cyc();
    chk1("t1_c0_ack", c0_ack, 1'b1);
    chk32("t1_c0_rd_data", c0_rd_data, 32'hDEADBEEF);
    chk1("t1_busy_clr", c0_busy, 1'b0);
    cyc();
    chk1("t1_ack_pulse_end", c0_ack, 1'b0);
    chk32("t1_rd_data_hold", c0_rd_data, 32'hDEADBEEF);

    // tie after reset: port 0 first, then the write from port 1
    do_reset();
    cyc();
    c0_rd_req = 1'b1; c0_addr = 32'h10;
    c1_wr_req = 1'b1; c1_addr = 32'h20; c1_wr_data = 32'h55;
    cyc();
    c0_rd_req = 1'b0; c1_wr_req = 1'b0;
    cyc();
    chk1("t2_rd_first", mem_rd_req, 1'b1);
    chk1("t2_no_wr_first", mem_wr_req, 1'b0);
    chk32("t2_addr_first", mem_addr, 32'h10);
    cyc();
    cyc();
    chk1("t2_c0_ack", c0_ack, 1'b1);
    chk1("t2_wr_after_ack", mem_wr_req, 1'b0);
    cyc();
    chk1("t2_mem_wr_req", mem_wr_req, 1'b1);
    chk32("t2_wr_addr", mem_addr, 32'h20);
    chk32("t2_wr_data", mem_wr_data, 32'h55);
    cyc();
    cyc();
    chk1("t2_c1_ack", c1_ack, 1'b1);
    chk32("t2_c1_rd_data", c1_rd_data, 32'd0);
    chk1("t2_c1_busy_clr", c1_busy, 1'b0);

    // fairness: both re-request right after each ack, 3 each
    cyc();
    c0_rd_req = 1'b1; c0_addr = 32'h100;
    c1_rd_req = 1'b1; c1_addr = 32'h200;
    n0 = 1; n1 = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      c0_rd_req = 1'b0; c1_rd_req = 1'b0;
      if (mem_rd_req || mem_wr_req) glog.push_back((mem_addr[9:8] == 2'b01) ? 0 : 1);
      if (c0_ack && n0 < 3) begin
        c0_rd_req = 1'b1; c0_addr = 32'h100 + n0; n0++;
      end
      if (c1_ack && n1 < 3) begin
        c1_rd_req = 1'b1; c1_addr = 32'h200 + n1; n1++;
      end
      if (glog.size() == 6 && !c0_busy && !c1_busy) break;
    end
    chk32("t3_grant_count", glog.size(), 32'd6);
    for (int i = 0; i < glog.size() && i < 6; i++) begin
      chk32($sformatf("t3_grant%0d", i), glog[i], i % 2);
    end

    // backpressure: mem_busy for 5 edges with c1 pending
    ack_delay = 1;
    cyc();
    mem_busy = 1'b1; c1_rd_req = 1'b1; c1_addr = 32'h300;
    cyc();
    c1_rd_req = 1'b0;
    chk1("t4_c1_busy", c1_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("t4_no_req%0d", i), mem_rd_req | mem_wr_req, 1'b0);
      cyc();
    end
    chk1("t4_no_req4", mem_rd_req | mem_wr_req, 1'b0);
    mem_busy = 1'b0;
    cyc();
    chk1("t4_issue", mem_rd_req, 1'b1);
    chk32("t4_addr", mem_addr, 32'h300);
    mem_busy = 1'b1;
    cyc();
    chk1("t4_busy_ignored_in_wait", c1_ack, 1'b1);
    chk32("t4_rd_data", c1_rd_data, 32'hC0DE_0307);
    mem_busy = 1'b0;

    // write+read together, then a dropped pulse while pending
    cyc();
    mem_busy = 1'b1;
    c0_wr_req = 1'b1; c0_rd_req = 1'b1; c0_addr = 32'h44; c0_wr_data = 32'h77;
    cyc();
    c0_wr_req = 1'b0; c0_rd_req = 1'b1; c0_addr = 32'h88; c0_wr_data = 32'h99;
    cyc();
    c0_rd_req = 1'b0; mem_busy = 1'b0;
    chk1("t4c_no_req", mem_rd_req | mem_wr_req, 1'b0);
    cyc();
    chk1("t4c_wr_only", mem_wr_req, 1'b1);
    chk1("t4c_no_rd", mem_rd_req, 1'b0);
    chk32("t4c_addr_kept", mem_addr, 32'h44);
    chk32("t4c_data_kept", mem_wr_data, 32'h77);
    cyc();
    chk1("t4c_ack", c0_ack, 1'b1);
    chk32("t4c_wr_rd_data", c0_rd_data, 32'd0);
    cyc();
    cyc();
    chk1("t4c_idle", c0_busy | mem_rd_req | mem_wr_req, 1'b0);

    // timeout: load nonzero rd_data first, then a read that never acks
    cyc();
    c0_rd_req = 1'b1; c0_addr = 32'h40;
    cyc();
    c0_rd_req = 1'b0;
    cyc();
    cyc();
    chk32("t5_pre_rd", c0_rd_data, 32'hDEADBEEF);
    mem_mute = 1'b1;
    cyc();
    c0_rd_req = 1'b1; c0_addr = 32'h50;
    cyc();
    c0_rd_req = 1'b0;
    cyc();
    chk1("t5_grant", mem_rd_req, 1'b1);
    repeat (7) cyc();
    chk1("t5_no_err_early", err, 1'b0);
    chk1("t5_no_ack_early", c0_ack, 1'b0);
    chk1("t5_busy_early", c0_busy, 1'b1);
    cyc();
    chk1("t5_err", err, 1'b1);
    chk1("t5_c0_ack", c0_ack, 1'b1);
    chk32("t5_rd_zero", c0_rd_data, 32'd0);
    chk1("t5_busy_clr", c0_busy, 1'b0);
    cyc();
    chk1("t5_err_pulse_end", err, 1'b0);
    chk1("t5_ack_pulse_end", c0_ack, 1'b0);

    // reset mid-WAIT, then a late ack
    cyc();
    c1_rd_req = 1'b1; c1_addr = 32'h60;
    cyc();
    c1_rd_req = 1'b0;
    cyc();
    chk1("t6_grant", mem_rd_req, 1'b1);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk1("t6_rst_c1_busy", c1_busy, 1'b0);
    chk32("t6_rst_addr", mem_addr, 32'd0);
    chk32("t6_rst_c1_rd", c1_rd_data, 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    late_ack = 1'b1;
    cyc();
    late_ack = 1'b0;
    chk1("t6_no_c1_ack", c1_ack, 1'b0);
    chk1("t6_no_c0_ack", c0_ack, 1'b0);
    chk1("t6_no_err", err, 1'b0);
    chk1("t6_no_mem_req", mem_rd_req | mem_wr_req, 1'b0);
    chk32("t6_addr_zero", mem_addr, 32'd0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
